execute_stage: RTL

- Pipeline EX stage. Sits directly downstream of the register file read stage and consumes its negedge-registered operands plus the buffered source addresses.
- Resolves data hazards by forwarding from its own EX/MEM register and from the write-back port.
- Performs the 16-bit ALU operation and keeps the condition-code register.
- Registers the result and control bits into the EX/MEM pipeline register, which feeds the memory stage.

---
 rtl/execute_stage_pkg.sv | 21 ++
 rtl/execute_stage_forward_mux.sv | 36 +++
 rtl/execute_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: default widths,
// ALU opcodes and condition-code bit positions.
package execute_stage_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_MOV = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOT = 3'd6;
    localparam logic [2:0] ALU_INC = 3'd7;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/execute_stage_forward_mux.sv
// Operand bypass select: EX/MEM result, then write-back data,
// then the register-file value. Also exposes the raw EX/MEM
// address match so the top can build the load-use hazard term.
// Ports: src_data/src_addr in, EX/MEM and WB bypass sources in,
//        data out (selected operand), exmem_match out.
module forward_mux #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic [DATA_W-1:0] src_data,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic              exmem_fwd_ok,
    input  logic [ADDR_W-1:0] exmem_dest,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic              exmem_match
);

    logic wb_match;

    assign exmem_match = (exmem_dest == src_addr);
    assign wb_match    = wb_reg_write && (wb_addr == src_addr);

    // EX/MEM holds the newer value, so it beats write-back.
    always_comb begin
        data = src_data;
        if (exmem_fwd_ok && exmem_match)
            data = exmem_result;
        else if (wb_match)
            data = wb_data;
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, 16-bit ALU, condition codes
// and the EX/MEM pipeline register feeding the memory stage.
// Ports: clk, reset (async, active low); register-file operands
//        and addresses; control (alu_op, dest, rd/wr enables,
//        stall, flush); write-back bypass; exmem_* register
//        outputs, flags {Z,N,C}, combinational load_use_hazard.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] src1_data,
    input  logic [DATA_W-1:0] src2_data,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    input  logic              one_operand,
    input  logic [2:0]        alu_op,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              reg_write_in,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] exmem_result,
    output logic [DATA_W-1:0] exmem_store_data,
    output logic [ADDR_W-1:0] exmem_dest,
    output logic              exmem_reg_write,
    output logic              exmem_mem_write,
    output logic              exmem_mem_read,
    output logic [2:0]        flags,
    output logic              load_use_hazard
);

    logic              exmem_fwd_ok;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    logic              match1;
    logic              match2;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // A pending load has no data yet; it must not be bypassed.
    assign exmem_fwd_ok = exmem_reg_write && !exmem_mem_read;

    forward_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
        .src_data     (src1_data),
        .src_addr     (src1_addr),
        .exmem_fwd_ok (exmem_fwd_ok),
        .exmem_dest   (exmem_dest),
        .exmem_result (exmem_result),
        .wb_reg_write (wb_reg_write),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .data         (fwd1),
        .exmem_match  (match1)
    );

    forward_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
        .src_data     (src2_data),
        .src_addr     (src2_addr),
        .exmem_fwd_ok (exmem_fwd_ok),
        .exmem_dest   (exmem_dest),
        .exmem_result (exmem_result),
        .wb_reg_write (wb_reg_write),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .data         (fwd2),
        .exmem_match  (match2)
    );

    assign op_a = fwd1;
    assign op_b = one_operand ? fwd1 : fwd2;

    assign load_use_hazard = exmem_mem_read && exmem_reg_write &&
                             (match1 || (!one_operand && match2));

    logic              is_mem;
    logic [DATA_W:0]   a_x;
    logic [DATA_W:0]   b_x;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   incr;
    logic [DATA_W-1:0] result;
    logic [2:0]        next_flags;

    assign is_mem = mem_read_in || mem_write_in;
    assign a_x    = {1'b0, op_a};
    assign b_x    = {1'b0, op_b};
    assign sum    = a_x + b_x;
    assign diff   = a_x - b_x;
    assign incr   = a_x + (DATA_W+1)'(1);

    always_comb begin
        result     = '0;
        next_flags = flags;
        if (is_mem) begin
            result = op_a;
        end else begin
            unique case (alu_op)
                ALU_NOP: result = '0;
                ALU_MOV: result = op_a;
                ALU_ADD: begin
                    result             = sum[DATA_W-1:0];
                    next_flags[FLAG_C] = sum[DATA_W];
                end
                ALU_SUB: begin
                    result             = diff[DATA_W-1:0];
                    // Top bit of the widened difference is the borrow.
                    next_flags[FLAG_C] = diff[DATA_W];
                end
                ALU_AND: result = op_a & op_b;
                ALU_OR:  result = op_a | op_b;
                ALU_NOT: result = ~op_a;
                ALU_INC: begin
                    result             = incr[DATA_W-1:0];
                    next_flags[FLAG_C] = incr[DATA_W];
                end
                default: result = '0;
            endcase
            if (alu_op != ALU_NOP && alu_op != ALU_MOV) begin
                next_flags[FLAG_Z] = (result == '0);
                next_flags[FLAG_N] = result[DATA_W-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_result     <= '0;
            exmem_store_data <= '0;
            exmem_dest       <= '0;
            exmem_reg_write  <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_mem_read   <= 1'b0;
            flags            <= 3'b000;
        end else if (flush) begin
            exmem_result     <= '0;
            exmem_store_data <= '0;
            exmem_dest       <= '0;
            exmem_reg_write  <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_mem_read   <= 1'b0;
        end else if (!stall) begin
            exmem_result     <= result;
            exmem_store_data <= op_b;
            exmem_dest       <= dest_addr;
            exmem_reg_write  <= reg_write_in;
            exmem_mem_write  <= mem_write_in;
            exmem_mem_read   <= mem_read_in;
            flags            <= next_flags;
        end
    end

endmodule
